// File: rtl/run_control.sv
// run_control: CPU clock sequencer clocked by the board clock.
// Generates one-clk-wide cpu_clk pulses in HALT / RUN / single clock step /
// single instruction step modes, with an 8-bit PR breakpoint and a
// wrapping count of issued CPU cycles.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_HALT  | cpu_clk held low, waiting for a run or step request
// ST_RUN   | free-running pulses at the divider rate, breakpoint checked
// ST_STEP_C| one pulse when due, then back to HALT after its high phase
// ST_STEP_I| pulses until sc samples 0 after a pulse, capped at 8 pulses
module run_control #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_clk_req,
   input  logic             step_inst_req,
   input  logic [DIV_W-1:0] div_val,
   input  logic             brk_set,
   input  logic             brk_clr,
   input  logic [7:0]       brk_val,
   input  logic             cnt_clr,
   input  logic [7:0]       pr,
   input  logic [2:0]       sc,
   output logic             cpu_clk,
   output logic [1:0]       state,
   output logic             brk_valid,
   output logic             brk_hit,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {
      ST_HALT   = 2'b00,
      ST_RUN    = 2'b01,
      ST_STEP_C = 2'b10,
      ST_STEP_I = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic             cpu_clk_q, cpu_clk_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             first_q, first_d;
   logic [3:0]       pcnt_q, pcnt_d;
   logic             post_q, post_d;
   logic [7:0]       brk_adrs_q, brk_adrs_d;
   logic             brk_valid_q, brk_valid_d;
   logic             brk_hit_q, brk_hit_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;

   logic due;
   logic brk_match;

   assign due       = (div_cnt_q >= div_val);
   // first_q lets a RUN started on the breakpoint address make progress
   assign brk_match = brk_valid_q && (pr == brk_adrs_q) && (sc == 3'd0) && !first_q;

   // Next-state: request arbitration, divider, breakpoint and step termination
   always_comb begin
      state_d   = state_q;
      cpu_clk_d = 1'b0;
      div_cnt_d = div_cnt_q;
      first_d   = first_q;
      pcnt_d    = pcnt_q;
      post_d    = 1'b0;
      brk_hit_d = brk_hit_q;
      cyc_d     = cyc_q;

      if (cpu_clk_q) begin
         // high phase always ends after one clk; only halt is honoured here
         post_d = 1'b1;
         if (halt_req || (state_q == ST_STEP_C)) begin
            state_d = ST_HALT;
         end
      end else if (halt_req) begin
         state_d   = ST_HALT;
         div_cnt_d = '0;
      end else if (run_req) begin
         state_d   = ST_RUN;
         div_cnt_d = '0;
         brk_hit_d = 1'b0;
         first_d   = 1'b1;
         pcnt_d    = '0;
      end else if ((state_q == ST_HALT) && step_inst_req) begin
         state_d   = ST_STEP_I;
         div_cnt_d = '0;
         brk_hit_d = 1'b0;
         first_d   = 1'b1;
         pcnt_d    = '0;
      end else if ((state_q == ST_HALT) && step_clk_req) begin
         state_d   = ST_STEP_C;
         div_cnt_d = '0;
         brk_hit_d = 1'b0;
         first_d   = 1'b1;
         pcnt_d    = '0;
      end else if (state_q != ST_HALT) begin
         // sc is only meaningful once the CPU has seen the preceding edge
         if ((state_q == ST_STEP_I) && post_q && ((sc == 3'd0) || (pcnt_q == 4'd8))) begin
            state_d   = ST_HALT;
            div_cnt_d = '0;
         end else if (due) begin
            if ((state_q == ST_RUN) && brk_match) begin
               state_d   = ST_HALT;
               brk_hit_d = 1'b1;
               div_cnt_d = '0;
            end else begin
               cpu_clk_d = 1'b1;
               div_cnt_d = '0;
               first_d   = 1'b0;
               cyc_d     = cyc_q + CNT_W'(1);
               if (state_q == ST_STEP_I) begin
                  pcnt_d = pcnt_q + 4'd1;
               end
            end
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end
      end

      if (cnt_clr) begin
         cyc_d = '0;
      end
   end

   // Breakpoint register: clear beats set, address loads on any set
   always_comb begin
      brk_adrs_d  = brk_set ? brk_val : brk_adrs_q;
      brk_valid_d = brk_valid_q;
      if (brk_clr) begin
         brk_valid_d = 1'b0;
      end else if (brk_set) begin
         brk_valid_d = 1'b1;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_HALT;
         cpu_clk_q   <= 1'b0;
         div_cnt_q   <= '0;
         first_q     <= 1'b0;
         pcnt_q      <= '0;
         post_q      <= 1'b0;
         brk_adrs_q  <= 8'h00;
         brk_valid_q <= 1'b0;
         brk_hit_q   <= 1'b0;
         cyc_q       <= '0;
      end else begin
         state_q     <= state_d;
         cpu_clk_q   <= cpu_clk_d;
         div_cnt_q   <= div_cnt_d;
         first_q     <= first_d;
         pcnt_q      <= pcnt_d;
         post_q      <= post_d;
         brk_adrs_q  <= brk_adrs_d;
         brk_valid_q <= brk_valid_d;
         brk_hit_q   <= brk_hit_d;
         cyc_q       <= cyc_d;
      end
   end

   assign cpu_clk   = cpu_clk_q;
   assign state     = state_q;
   assign brk_valid = brk_valid_q;
   assign brk_hit   = brk_hit_q;
   assign cycle_cnt = cyc_q;

endmodule

// File: doc/run_control.md
Name: run_control

Overview:
Sequencing controller for the CPU clock. It replaces the raw push-button/oscillator mux that drives the CPU clock and is clocked by the board clock. It generates a one-clk-wide cpu_clk high pulse per CPU cycle in four modes: HALT, RUN at a programmable rate, single clock step, and single instruction step (until sc returns to 0). It also supports an 8-bit PR breakpoint and keeps a CPU-cycle counter for the 7-segment and LED display.

Parameters:
DIV_W, 16, width of the run-rate divider and div_val.
CNT_W, 16, width of cycle_cnt.

Ports:
clk  in  1  board clock; all state on rising edge.
rst  in  1  asynchronous active-low reset.
run_req  in  1  one-clk pulse: enter RUN.
halt_req  in  1  one-clk pulse: enter HALT.
step_clk_req  in  1  one-clk pulse: issue exactly one CPU cycle.
step_inst_req  in  1  one-clk pulse: run to the next instruction boundary.
div_val  in  DIV_W  RUN/STEP_I low-phase length minus 1.
brk_set  in  1  one-clk pulse: load brk_adrs <= brk_val and set brk_valid.
brk_clr  in  1  one-clk pulse: clear brk_valid.
brk_val  in  8  breakpoint address.
cnt_clr  in  1  one-clk pulse: clear cycle_cnt.
pr  in  8  CPU program register.
sc  in  3  CPU step counter.
cpu_clk  out  1  registered CPU clock, high exactly 1 clk per CPU cycle.
state  out  2  00 HALT, 01 RUN, 10 STEP_C, 11 STEP_I.
brk_valid  out  1  breakpoint armed.
brk_hit  out  1  sticky: RUN stopped on the breakpoint.
cycle_cnt  out  CNT_W  cpu_clk rising edges issued; wraps.

Behaviour:
- Reset (rst=0, async) values:
  - state=HALT, cpu_clk=0, brk_valid=0, brk_hit=0, cycle_cnt=0.
  - Divider count=0, first flag=0, step pulse count=0.
  - brk_adrs=8'h00.
- Internal divider:
  - Counts clks while cpu_clk=0 in a non-HALT state.
  - A pulse is due when count >= div_val.
  - When a pulse issues: cpu_clk=1 for one clk, count cleared, cycle_cnt+1.
  - Period = div_val+2 clks. div_val=0 gives a period of 2 clks.
  - div_val changes take effect immediately. If count already exceeds the new value, the pulse issues on the next clk.
- Requests are accepted only when no CPU cycle is mid-flight.
  - Priority: halt_req > run_req > step_inst_req > step_clk_req.
  - Requests are ignored while cpu_clk=1, except halt_req, which takes effect the clk after the high phase.
  - Accepting run/step clears count and brk_hit and sets the first flag.
- HALT: cpu_clk held 0. run_req->RUN; step_inst_req->STEP_I; step_clk_req->STEP_C.
- RUN:
  - Pulses at the divider rate.
  - Breakpoint check: at the clk a pulse would issue, if brk_valid and pr==brk_adrs and sc==0 and first flag=0, no pulse issues. state->HALT and brk_hit=1.
  - First flag clears after the first pulse, so RUN started at the breakpoint makes progress.
  - halt_req->HALT.
  - step requests in RUN are ignored.
- STEP_C: issues exactly one pulse when due, then returns to HALT the clk after the high phase. Breakpoint is ignored.
- STEP_I:
  - Pulses at the divider rate.
  - In the clk after each high phase, sample sc. If sc==0 and at least one pulse was issued, go to HALT.
  - Safety cap: HALT after 8 pulses regardless of sc.
  - Breakpoint is ignored.
- brk_set and brk_clr in the same clk: clr wins, and brk_adrs is still loaded. Both are accepted in any state.
- cnt_clr: cycle_cnt=0 next clk. If a pulse issues in the same clk, clr wins and the result is 0.
- cycle_cnt wraps from all-ones to 0.
- Reset asserted mid-pulse: cpu_clk drops to 0 immediately.
- No combinational path from any input to cpu_clk.

Test Plan:
- Reset, then step_clk_req once -> exactly one cpu_clk high clk; state 10 then 00; cycle_cnt=1.
- div_val=3, run_req, 20 clks, then halt_req -> cpu_clk period 5 clks; high 1 clk each; no pulse after halt; state=00.
- brk_set with brk_val=8'h05; RUN with a pr/sc model (pr+1 each time sc wraps from 4 to 0) -> halt with pr=05, sc=0, brk_hit=1. run_req again -> first pulse issues and brk_hit clears.
- step_inst_req with sc=2 -> pulses until sc samples 0, then HALT. Holding sc=3 constant -> HALT after exactly 8 pulses.
- div_val 10->0 while count=5 in RUN -> pulse the next clk, then period 2.
- brk_set and brk_clr in the same clk -> brk_valid=0 and brk_adrs updated. cnt_clr coincident with a pulse -> cycle_cnt=0. rst low mid-high-phase -> cpu_clk=0 asynchronously and all outputs at reset values.
